uart_axi_regs: RTL and testbench
================================

// Module: uart_axi_regs
// PURPOSE
//  AXI4 slave register bank; the downstream consumer of the UART-to-AXI master's m_axi_* port.
//  Holds P_NREG 32-bit RW registers, accepts single/burst writes and reads, exports all registers.
//  Gives the UART debug bridge a concrete target for bring-up and control/config storage.
// PARAMETERS
//  P_AW    16  address width (matches master awaddr/araddr)
//  P_NREG  16  number of 32-bit registers; word index = addr[P_AW-1:2]
// PORTS
//  aclk           in   1            clock (100MHz)
//  rst            in   1            synchronous reset, active-high
//  s_axi_aw*      in   per AXI4     awaddr[P_AW],awlen[8],awsize[3],awburst[2],awvalid; lock/cache/prot ignored
//  s_axi_awready  out  1            AW accept
//  s_axi_wdata    in   32           write data
//  s_axi_wstrb    in   4            byte enables
//  s_axi_wlast/wvalid in 1          W beat qualifiers
//  s_axi_wready   out  1            W accept
//  s_axi_bresp    out  2            OKAY=0 / SLVERR=2
//  s_axi_bvalid   out  1 ; s_axi_bready in 1
//  s_axi_ar*      in   per AXI4     araddr,arlen,arsize,arburst,arvalid ; s_axi_arready out 1
//  s_axi_rdata    out  32 ; s_axi_rresp out 2 ; s_axi_rlast out 1 ; s_axi_rvalid out 1 ; s_axi_rready in 1
//  o_regs         out  32*P_NREG    register contents, reg k at [32k+31:32k]
// BEHAVIOUR
//  Reset (rst=1 at aclk edge): all regs 0, FSMs idle; awready/arready/wready/bvalid/rvalid/rlast=0,
//   bresp/rresp/rdata=0. awready/arready=1 from first cycle after rst deasserts.
//  Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE; read FSM R_IDLE->R_DATA->R_IDLE; fully independent.
//  W_IDLE: awready=1; AW handshake latches addr, len, burst, err=0, beat=0 -> W_DATA (awready 0 next cycle).
//  W_DATA: wready=1; each W handshake writes enabled bytes of reg[idx] when beat legal; beat++.
//   Transition to W_RESP after exactly awlen+1 beats; wlast consulted only for checking.
//  W_RESP: bvalid=1, bresp=err?SLVERR:OKAY; held until bready; then W_IDLE, awready=1 next cycle.
//  Beat legal: size==2 and idx<P_NREG and burst supported. Illegal beat: no write, err=1.
//  wlast mismatch (early, or missing on last beat): err=1; data of legal beats still committed.
//  Address step: FIXED no change; INCR +4, wraps modulo 2^P_AW; burst 2'b11 unsupported.
//  R_IDLE: arready=1; AR handshake -> R_DATA; rvalid=1 the next cycle (1-cycle latency).
//  R_DATA: rdata=reg[idx] (0 if illegal), rresp per-beat OKAY/SLVERR, rlast on beat arlen.
//   Outputs held stable while rvalid&!rready; on handshake next beat loads next cycle; after rlast -> R_IDLE.
//  Same-cycle write and read beat to one register: read returns pre-write value.
//  o_regs updates the cycle after the write beat. rst mid-burst aborts both FSMs, no response issued.
// CONFIGURATION
//  UART_AXI_REGS_WRAP_EN defined: WRAP bursts (2'b10) legal for len 1/3/7/15; address wraps within
//   aligned (len+1)*4-byte window; other lens SLVERR, no write.
//  Not defined: WRAP treated as unsupported -> all beats SLVERR, no writes, reads return 0.
// STRUCTURE
//  Package uart_axi_pkg: AXI resp constants (RESP_OKAY, RESP_SLVERR), burst constants
//   (BURST_FIXED/INCR/WRAP), FSM state enums, next-address function shared by both FSMs.
//  Sub-module uart_axi_addr_gen (addr, len, burst, size -> next addr, legal flag), one per FSM.
// TESTING
//  Single write 0x0004 data 0xDEADBEEF strb 0xF, then read -> rdata 0xDEADBEEF, OKAY, rlast=1.
//  Write strb 0x3 data 0x11223344 over 0xAAAAAAAA at reg 2 -> readback 0xAAAA3344.
//  INCR write len=3 from 0x0038 (P_NREG=16) -> regs 14,15 written; 0x0040/44 dropped; bresp SLVERR.
//  INCR read len=3 with rready low 5 cycles on beat 1 -> rdata/rlast stable; 4 beats, rlast on 4th.
//  awsize=1 write -> no reg change, SLVERR; wlast on beat 2 of len=3 -> SLVERR, 4 beats accepted.
//  WRAP len=3 from 0x0008: with _EN writes idx 2,3,0,1 OKAY; without, SLVERR and no writes.

Source files
------------

// File: rtl/uart_axi_pkg.sv
// uart_axi_pkg
//   Shared definitions for the uart_axi_regs AXI4 register-bank slave:
//   AXI response and burst encodings, write/read FSM state types, and the
//   next-beat address function used by both the write and read channels.
package uart_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

   // Address of the following beat for 4-byte beats. The WRAP window is
   // (len+1)*4 bytes, so its offset mask is {len, 2'b11}; only the offset
   // bits advance, the aligned window base stays put.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [7:0]  len,
                                             input logic [1:0]  burst);
      logic [31:0] mask;
      logic [31:0] res;
      mask = {22'd0, len, 2'b11};
      case (burst)
         BURST_FIXED: res = addr;
         BURST_INCR:  res = addr + 32'd4;
         BURST_WRAP:  res = (addr & ~mask) | ((addr + 32'd4) & mask);
         default:     res = addr;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/uart_axi_addr_gen.sv
// uart_axi_addr_gen
//   Combinational beat decoder: from the current beat address and the burst
//   attributes, produces the next beat address and whether this beat may
//   touch the register bank.
//   Optional feature macro: UART_AXI_REGS_WRAP_EN (WRAP bursts of length
//   2/4/8/16 become legal; without it WRAP is always illegal).
// Ports
//   addr  in  P_AW  current beat address
//   len   in  8     AXI burst length (beats-1)
//   burst in  2     AXI burst type
//   size  in  3     AXI beat size (only 3'd2, 4 bytes, is legal)
//   next  out P_AW  address of the following beat (wraps modulo 2^P_AW)
//   legal out 1     beat targets an existing register with a supported burst
module uart_axi_addr_gen
   import uart_axi_pkg::*;
#(
   parameter int P_AW   = 16,
   parameter int P_NREG = 16
) (
   input  logic [P_AW-1:0] addr,
   input  logic [7:0]      len,
   input  logic [1:0]      burst,
   input  logic [2:0]      size,
   output logic [P_AW-1:0] next,
   output logic            legal
);

   logic wrap_ok;
   logic burst_ok;
   logic idx_ok;

   // Truncating back to P_AW gives the modulo-2^P_AW address wrap for free.
   assign next = P_AW'(next_addr(32'(addr), len, burst));

`ifdef UART_AXI_REGS_WRAP_EN
   assign wrap_ok = (burst == BURST_WRAP) &&
                    ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
`else
   assign wrap_ok = 1'b0;
`endif

   assign burst_ok = (burst == BURST_FIXED) || (burst == BURST_INCR) || wrap_ok;
   assign idx_ok   = (32'(addr[P_AW-1:2]) < 32'(P_NREG));
   assign legal    = (size == 3'd2) && burst_ok && idx_ok;

endmodule

// File: rtl/uart_axi_regs.sv
// uart_axi_regs
//   AXI4 slave bank of P_NREG 32-bit read/write registers, target of the
//   UART-to-AXI debug bridge. Independent write (AW/W/B) and read (AR/R)
//   FSMs; all AXI outputs are registered. Illegal beats (wrong size,
//   unsupported burst, index >= P_NREG) are dropped and answered SLVERR.
//   Optional feature macro: UART_AXI_REGS_WRAP_EN (see uart_axi_addr_gen).
// Ports
//   aclk, rst            clock, synchronous active-high reset
//   s_axi_aw*            write address channel (addr/len/size/burst/valid/ready)
//   s_axi_w*             write data channel (data/strb/last/valid/ready)
//   s_axi_b*             write response channel (resp/valid/ready)
//   s_axi_ar*            read address channel (addr/len/size/burst/valid/ready)
//   s_axi_r*             read data channel (data/resp/last/valid/ready)
//   o_regs               all registers, reg k at [32k+31:32k]
module uart_axi_regs
   import uart_axi_pkg::*;
#(
   parameter int P_AW   = 16,
   parameter int P_NREG = 16
) (
   input  logic                   aclk,
   input  logic                   rst,
   input  logic [P_AW-1:0]        s_axi_awaddr,
   input  logic [7:0]             s_axi_awlen,
   input  logic [2:0]             s_axi_awsize,
   input  logic [1:0]             s_axi_awburst,
   input  logic                   s_axi_awvalid,
   output logic                   s_axi_awready,
   input  logic [31:0]            s_axi_wdata,
   input  logic [3:0]             s_axi_wstrb,
   input  logic                   s_axi_wlast,
   input  logic                   s_axi_wvalid,
   output logic                   s_axi_wready,
   output logic [1:0]             s_axi_bresp,
   output logic                   s_axi_bvalid,
   input  logic                   s_axi_bready,
   input  logic [P_AW-1:0]        s_axi_araddr,
   input  logic [7:0]             s_axi_arlen,
   input  logic [2:0]             s_axi_arsize,
   input  logic [1:0]             s_axi_arburst,
   input  logic                   s_axi_arvalid,
   output logic                   s_axi_arready,
   output logic [31:0]            s_axi_rdata,
   output logic [1:0]             s_axi_rresp,
   output logic                   s_axi_rlast,
   output logic                   s_axi_rvalid,
   input  logic                   s_axi_rready,
   output logic [32*P_NREG-1:0]   o_regs
);

   localparam int IW = (P_NREG > 1) ? $clog2(P_NREG) : 1;

   logic [31:0] regs [P_NREG];

   // ---------------- write channel ----------------
   wr_state_t       w_state, w_state_nxt;
   logic [P_AW-1:0] w_addr, w_addr_nxt, w_next;
   logic [7:0]      w_len, w_len_nxt, w_beat, w_beat_nxt;
   logic [1:0]      w_burst, w_burst_nxt, bresp_nxt;
   logic [2:0]      w_size, w_size_nxt;
   logic            w_err, w_err_nxt, w_legal, w_last_beat, wr_en;
   logic            awready_nxt, wready_nxt, bvalid_nxt;
   logic [IW-1:0]   w_idx;

   uart_axi_addr_gen #(.P_AW(P_AW), .P_NREG(P_NREG)) u_wr_gen (
      .addr(w_addr), .len(w_len), .burst(w_burst), .size(w_size),
      .next(w_next), .legal(w_legal)
   );

   assign w_last_beat = (w_beat == w_len);
   assign w_idx       = w_addr[IW+1:2];

   // Write FSM next-state, beat bookkeeping and registered-output next values.
   always_comb begin
      w_state_nxt = w_state;
      w_addr_nxt  = w_addr;
      w_len_nxt   = w_len;
      w_burst_nxt = w_burst;
      w_size_nxt  = w_size;
      w_err_nxt   = w_err;
      w_beat_nxt  = w_beat;
      awready_nxt = 1'b0;
      wready_nxt  = 1'b0;
      bvalid_nxt  = 1'b0;
      bresp_nxt   = s_axi_bresp;
      wr_en       = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (s_axi_awvalid && s_axi_awready) begin
               w_state_nxt = W_DATA;
               w_addr_nxt  = s_axi_awaddr;
               w_len_nxt   = s_axi_awlen;
               w_burst_nxt = s_axi_awburst;
               w_size_nxt  = s_axi_awsize;
               w_err_nxt   = 1'b0;
               w_beat_nxt  = 8'd0;
               wready_nxt  = 1'b1;
            end else begin
               awready_nxt = 1'b1;
            end
         end
         W_DATA: begin
            if (s_axi_wvalid && s_axi_wready) begin
               wr_en      = w_legal;
               // The beat count alone ends the burst; wlast only flags errors.
               w_err_nxt  = w_err | ~w_legal | (s_axi_wlast ^ w_last_beat);
               w_addr_nxt = w_next;
               w_beat_nxt = w_beat + 8'd1;
               if (w_last_beat) begin
                  w_state_nxt = W_RESP;
                  bvalid_nxt  = 1'b1;
                  bresp_nxt   = w_err_nxt ? RESP_SLVERR : RESP_OKAY;
               end else begin
                  wready_nxt = 1'b1;
               end
            end else begin
               wready_nxt = 1'b1;
            end
         end
         W_RESP: begin
            if (s_axi_bvalid && s_axi_bready) begin
               w_state_nxt = W_IDLE;
               awready_nxt = 1'b1;
               bresp_nxt   = RESP_OKAY;
            end else begin
               bvalid_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = W_IDLE;
         end
      endcase
   end

   // Write FSM state, burst context and registered AW/W/B outputs.
   always_ff @(posedge aclk) begin
      if (rst) begin
         w_state       <= W_IDLE;
         w_addr        <= '0;
         w_len         <= 8'd0;
         w_burst       <= 2'd0;
         w_size        <= 3'd0;
         w_err         <= 1'b0;
         w_beat        <= 8'd0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
      end else begin
         w_state       <= w_state_nxt;
         w_addr        <= w_addr_nxt;
         w_len         <= w_len_nxt;
         w_burst       <= w_burst_nxt;
         w_size        <= w_size_nxt;
         w_err         <= w_err_nxt;
         w_beat        <= w_beat_nxt;
         s_axi_awready <= awready_nxt;
         s_axi_wready  <= wready_nxt;
         s_axi_bvalid  <= bvalid_nxt;
         s_axi_bresp   <= bresp_nxt;
      end
   end

   // Register file: byte-enabled update from each legal write beat.
   always_ff @(posedge aclk) begin
      if (rst) begin
         for (int k = 0; k < P_NREG; k++) regs[k] <= 32'd0;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (s_axi_wstrb[b]) regs[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
         end
      end
   end

   for (genvar k = 0; k < P_NREG; k++) begin : g_out
      assign o_regs[32*k +: 32] = regs[k];
   end

   // ---------------- read channel ----------------
   rd_state_t       r_state, r_state_nxt;
   logic [P_AW-1:0] r_addr, r_addr_nxt, rg_addr, rg_next;
   logic [7:0]      r_len, r_len_nxt, rg_len, r_beat, r_beat_nxt;
   logic [1:0]      r_burst, r_burst_nxt, rg_burst, rresp_nxt;
   logic [2:0]      r_size, r_size_nxt, rg_size;
   logic            r_legal, arready_nxt, rvalid_nxt, rlast_nxt;
   logic [31:0]     r_word, rdata_nxt;
   logic [IW-1:0]   r_idx;

   // While idle the decoder looks at the AR request itself so beat 0 can be
   // loaded on the handshake edge; afterwards it looks at the next-beat address.
   assign rg_addr  = (r_state == R_IDLE) ? s_axi_araddr  : r_addr;
   assign rg_len   = (r_state == R_IDLE) ? s_axi_arlen   : r_len;
   assign rg_burst = (r_state == R_IDLE) ? s_axi_arburst : r_burst;
   assign rg_size  = (r_state == R_IDLE) ? s_axi_arsize  : r_size;
   assign r_idx    = rg_addr[IW+1:2];
   assign r_word   = r_legal ? regs[r_idx] : 32'd0;

   uart_axi_addr_gen #(.P_AW(P_AW), .P_NREG(P_NREG)) u_rd_gen (
      .addr(rg_addr), .len(rg_len), .burst(rg_burst), .size(rg_size),
      .next(rg_next), .legal(r_legal)
   );

   // Read FSM next-state and next values of the registered R outputs.
   always_comb begin
      r_state_nxt = r_state;
      r_addr_nxt  = r_addr;
      r_len_nxt   = r_len;
      r_burst_nxt = r_burst;
      r_size_nxt  = r_size;
      r_beat_nxt  = r_beat;
      arready_nxt = 1'b0;
      rvalid_nxt  = s_axi_rvalid;
      rdata_nxt   = s_axi_rdata;
      rresp_nxt   = s_axi_rresp;
      rlast_nxt   = s_axi_rlast;
      case (r_state)
         R_IDLE: begin
            if (s_axi_arvalid && s_axi_arready) begin
               r_state_nxt = R_DATA;
               r_addr_nxt  = rg_next;
               r_len_nxt   = s_axi_arlen;
               r_burst_nxt = s_axi_arburst;
               r_size_nxt  = s_axi_arsize;
               r_beat_nxt  = 8'd1;
               rvalid_nxt  = 1'b1;
               rdata_nxt   = r_word;
               rresp_nxt   = r_legal ? RESP_OKAY : RESP_SLVERR;
               rlast_nxt   = (s_axi_arlen == 8'd0);
            end else begin
               arready_nxt = 1'b1;
            end
         end
         R_DATA: begin
            if (s_axi_rvalid && s_axi_rready) begin
               if (s_axi_rlast) begin
                  r_state_nxt = R_IDLE;
                  arready_nxt = 1'b1;
                  rvalid_nxt  = 1'b0;
                  rdata_nxt   = 32'd0;
                  rresp_nxt   = RESP_OKAY;
                  rlast_nxt   = 1'b0;
               end else begin
                  r_addr_nxt = rg_next;
                  r_beat_nxt = r_beat + 8'd1;
                  rdata_nxt  = r_word;
                  rresp_nxt  = r_legal ? RESP_OKAY : RESP_SLVERR;
                  rlast_nxt  = (r_beat == r_len);
               end
            end else begin
               r_state_nxt = R_DATA;
            end
         end
         default: begin
            r_state_nxt = R_IDLE;
         end
      endcase
   end

   // Read FSM state, burst context and registered AR/R outputs.
   always_ff @(posedge aclk) begin
      if (rst) begin
         r_state       <= R_IDLE;
         r_addr        <= '0;
         r_len         <= 8'd0;
         r_burst       <= 2'd0;
         r_size        <= 3'd0;
         r_beat        <= 8'd0;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= 32'd0;
         s_axi_rresp   <= RESP_OKAY;
         s_axi_rlast   <= 1'b0;
      end else begin
         r_state       <= r_state_nxt;
         r_addr        <= r_addr_nxt;
         r_len         <= r_len_nxt;
         r_burst       <= r_burst_nxt;
         r_size        <= r_size_nxt;
         r_beat        <= r_beat_nxt;
         s_axi_arready <= arready_nxt;
         s_axi_rvalid  <= rvalid_nxt;
         s_axi_rdata   <= rdata_nxt;
         s_axi_rresp   <= rresp_nxt;
         s_axi_rlast   <= rlast_nxt;
      end
   end

endmodule

// File: tb/tb_uart_axi_regs.sv
// tb_uart_axi_regs
//   Self-checking bench for uart_axi_regs: directed scenarios plus randomized
//   write/read bursts compared against a behavioural register-bank model that
//   computes beat addresses and legality with plain arithmetic.
//   Honours UART_AXI_REGS_WRAP_EN the same way as the design.
module tb_uart_axi_regs;

`ifdef UART_AXI_REGS_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif
   localparam int NREG = 16;

   logic         aclk = 1'b0;
   logic         rst;
   logic [15:0]  awaddr, araddr;
   logic [7:0]   awlen, arlen;
   logic [2:0]   awsize, arsize;
   logic [1:0]   awburst, arburst;
   logic         awvalid, awready, arvalid, arready;
   logic [31:0]  wdata, rdata;
   logic [3:0]   wstrb;
   logic         wlast, wvalid, wready;
   logic [1:0]   bresp, rresp;
   logic         bvalid, bready, rlast, rvalid, rready;
   logic [32*NREG-1:0] o_regs;

   int errors = 0;
   int checks = 0;

   logic [31:0] wd    [16];
   logic [3:0]  ws    [16];
   logic [31:0] mregs [NREG];

   uart_axi_regs #(.P_AW(16), .P_NREG(NREG)) dut (
      .aclk(aclk), .rst(rst),
      .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
      .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
      .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .o_regs(o_regs)
   );

   always #5 aclk = ~aclk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte address of beat k of a burst, straight from the AXI burst rules.
   function automatic int beat_addr(input int start, input int len, input int burst, input int k);
      int w, base;
      case (burst)
         1: return (start + 4 * k) % 65536;
         2: begin
            w    = (len + 1) * 4;
            base = start - (start % w);
            return base + ((start - base + 4 * k) % w);
         end
         default: return start;
      endcase
   endfunction

   function automatic bit beat_legal(input int ad, input int len, input int burst, input int size);
      bit bok;
      bok = (burst == 0) || (burst == 1) ||
            (WRAP_EN && burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15));
      return (size == 2) && bok && (ad / 4 < NREG);
   endfunction

   task automatic check_regs(input string tag);
      for (int k = 0; k < NREG; k++)
         check_eq($sformatf("%s_reg%0d", tag, k), o_regs[32*k +: 32], mregs[k]);
   endtask

   task automatic aw_send(input int a, input int l, input int b, input int s);
      int n = 0;
      awaddr = 16'(a); awlen = 8'(l); awburst = 2'(b); awsize = 3'(s); awvalid = 1'b1;
      while (awready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
      check_eq("aw_wait", 32'(n < 50), 32'd1);
      @(posedge aclk); #1;
      awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] st, input bit last);
      int n = 0;
      wdata = d; wstrb = st; wlast = last; wvalid = 1'b1;
      while (wready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
      check_eq("w_wait", 32'(n < 50), 32'd1);
      @(posedge aclk); #1;
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   // Full write burst using wd/ws; wlast asserted on beat last_at.
   task automatic do_write(input int a, input int l, input int b, input int s, input int last_at);
      int  n = 0;
      int  ad;
      bit  exp_err;
      aw_send(a, l, b, s);
      for (int k = 0; k <= l; k++) w_send(wd[k], ws[k], (k == last_at));
      exp_err = (last_at != l);
      for (int k = 0; k <= l; k++) begin
         ad = beat_addr(a, l, b, k);
         if (beat_legal(ad, l, b, s)) begin
            for (int bb = 0; bb < 4; bb++)
               if (ws[k][bb]) mregs[ad/4][8*bb +: 8] = wd[k][8*bb +: 8];
         end else begin
            exp_err = 1'b1;
         end
      end
      repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      bready = 1'b1;
      while (bvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
      check_eq("b_wait", 32'(n < 50), 32'd1);
      check_eq("bresp", 32'(bresp), exp_err ? 32'd2 : 32'd0);
      @(posedge aclk); #1;
      bready = 1'b0;
      check_eq("bvalid_drop", 32'(bvalid), 32'd0);
      check_regs("wr");
   endtask

   // Full read burst; rready held low for stall_cyc cycles on beat stall_beat.
   task automatic do_read(input int a, input int l, input int b, input int s,
                          input int stall_beat, input int stall_cyc);
      int n = 0;
      int ad, nst;
      logic [31:0] expd;
      logic [31:0] expr;
      araddr = 16'(a); arlen = 8'(l); arburst = 2'(b); arsize = 3'(s); arvalid = 1'b1;
      while (arready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
      check_eq("ar_wait", 32'(n < 50), 32'd1);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      for (int k = 0; k <= l; k++) begin
         ad = beat_addr(a, l, b, k);
         if (beat_legal(ad, l, b, s)) begin
            expd = mregs[ad/4]; expr = 32'd0;
         end else begin
            expd = 32'd0; expr = 32'd2;
         end
         nst = (k == stall_beat) ? stall_cyc : 0;
         for (int c = 0; c < nst; c++) begin
            check_eq("r_hold_data", rdata, expd);
            check_eq("r_hold_last", 32'(rlast), 32'(k == l));
            @(posedge aclk); #1;
         end
         check_eq("rvalid", 32'(rvalid), 32'd1);
         check_eq("rdata", rdata, expd);
         check_eq("rresp", 32'(rresp), expr);
         check_eq("rlast", 32'(rlast), 32'(k == l));
         rready = 1'b1;
         @(posedge aclk); #1;
         rready = 1'b0;
      end
      check_eq("r_end", 32'(rvalid), 32'd0);
   endtask

   initial begin
      logic [31:0] keep [4];
      rst = 1'b1;
      awaddr = 16'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
      araddr = 16'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
      wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b0; rready = 1'b0;
      for (int k = 0; k < NREG; k++) mregs[k] = 32'd0;

      // Reset state
      repeat (2) @(posedge aclk);
      #1;
      check_eq("rst_awready", 32'(awready), 32'd0);
      check_eq("rst_arready", 32'(arready), 32'd0);
      check_eq("rst_wready",  32'(wready),  32'd0);
      check_eq("rst_bvalid",  32'(bvalid),  32'd0);
      check_eq("rst_rvalid",  32'(rvalid),  32'd0);
      check_eq("rst_rdata",   rdata,        32'd0);
      check_regs("rst");
      rst = 1'b0;
      @(posedge aclk); #1;
      check_eq("post_rst_awready", 32'(awready), 32'd1);
      check_eq("post_rst_arready", 32'(arready), 32'd1);

      // Single write / readback
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      do_write(16'h0004, 0, 1, 2, 0);
      check_eq("t1_reg1", o_regs[63:32], 32'hDEADBEEF);
      do_read(16'h0004, 0, 1, 2, -1, 0);

      // Partial strobes
      wd[0] = 32'hAAAAAAAA; ws[0] = 4'hF;
      do_write(16'h0008, 0, 1, 2, 0);
      wd[0] = 32'h11223344; ws[0] = 4'h3;
      do_write(16'h0008, 0, 1, 2, 0);
      check_eq("t2_reg2", o_regs[95:64], 32'hAAAA3344);
      do_read(16'h0008, 0, 1, 2, -1, 0);

      // INCR running past the last register
      for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      do_write(16'h0038, 3, 1, 2, 3);
      check_eq("t3_reg14", o_regs[14*32 +: 32], wd[0]);
      check_eq("t3_reg15", o_regs[15*32 +: 32], wd[1]);

      // Read with back-pressure on beat 1
      do_read(16'h0030, 3, 1, 2, 1, 5);

      // Bad size, early wlast
      wd[0] = 32'h55AA55AA; ws[0] = 4'hF;
      do_write(16'h0010, 0, 1, 1, 0);
      for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      do_write(16'h0014, 3, 1, 2, 1);
      check_eq("t5_reg8", o_regs[8*32 +: 32], wd[3]);

      // INCR address wrap at the top of the address space
      for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      do_write(16'hFFF8, 3, 1, 2, 3);
      check_eq("wrap64k_reg0", o_regs[31:0],  wd[2]);
      check_eq("wrap64k_reg1", o_regs[63:32], wd[3]);

      // WRAP burst len=3 from 0x0008
      for (int k = 0; k < 4; k++) begin keep[k] = mregs[k]; wd[k] = $urandom; ws[k] = 4'hF; end
      do_write(16'h0008, 3, 2, 2, 3);
`ifdef UART_AXI_REGS_WRAP_EN
      check_eq("wrap_reg2", o_regs[95:64],  wd[0]);
      check_eq("wrap_reg3", o_regs[127:96], wd[1]);
      check_eq("wrap_reg0", o_regs[31:0],   wd[2]);
      check_eq("wrap_reg1", o_regs[63:32],  wd[3]);
`else
      check_eq("wrap_reg2_kept", o_regs[95:64],  keep[2]);
      check_eq("wrap_reg0_kept", o_regs[31:0],   keep[0]);
`endif
      do_read(16'h0008, 3, 2, 2, -1, 0);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         int a, l, b, s, la;
         a = ($urandom_range(0, 4) == 0) ? 32'hFFE0 + $urandom_range(0, 31)
                                         : $urandom_range(0, 95);
         a = a - (a % 4);
         case ($urandom_range(0, 5))
            0: l = 0;
            1: l = 1;
            2: l = 3;
            3: l = 7;
            4: l = 15;
            default: l = $urandom_range(0, 15);
         endcase
         b  = ($urandom_range(0, 9) < 6) ? 1 : $urandom_range(0, 3);
         s  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : 2;
         la = ($urandom_range(0, 7) == 0) ? $urandom_range(0, l) : l;
         for (int k = 0; k <= l; k++) begin
            wd[k] = $urandom;
            ws[k] = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         end
         do_write(a, l, b, s, la);
         do_read(a, l, b, s, $urandom_range(0, l), $urandom_range(0, 3));
      end

      // Reset in the middle of a write burst: no response, bank cleared
      aw_send(16'h0000, 3, 1, 2);
      w_send(32'h12345678, 4'hF, 1'b0);
      w_send(32'h9ABCDEF0, 4'hF, 1'b0);
      rst = 1'b1;
      @(posedge aclk); #1;
      rst = 1'b0;
      for (int k = 0; k < NREG; k++) mregs[k] = 32'd0;
      check_eq("midrst_bvalid",  32'(bvalid),  32'd0);
      check_eq("midrst_wready",  32'(wready),  32'd0);
      check_eq("midrst_awready", 32'(awready), 32'd0);
      check_regs("midrst");
      @(posedge aclk); #1;
      check_eq("midrst_awready_back", 32'(awready), 32'd1);
      wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
      do_write(16'h0020, 0, 1, 2, 0);
      do_read(16'h0020, 0, 1, 2, 0, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
